// File: rtl/pipe_ifid_queue.sv
// IF->ID decoupling FIFO of {pc4, inst}; a push at edge N is visible at the head after edge N, with no bypass.
// Backpressure: if_ready = !full comes only from the registered count. flush empties the queue in one cycle.
module pipe_ifid_queue #(
  parameter int          DEPTH = 2,
  parameter int          AW    = 1,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          if_valid,
  input  logic [31:0]   if_pc4,
  input  logic [31:0]   if_inst,
  output logic          if_ready,
  input  logic          id_ready,
  input  logic          flush,
  output logic          id_valid,
  output logic [31:0]   dpc4,
  output logic [31:0]   dinst,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  assign if_ready = (count != FULL_CNT);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  assign head  = mem[rd_ptr];
  assign dpc4  = id_valid ? head[63:32] : 32'h0;
  assign dinst = id_valid ? head[31:0]  : NOP;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {if_pc4, if_inst};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

endmodule
